seven_seg_scroll_ctrl: RTL and testbench
========================================

// Module: seven_seg_scroll_ctrl
// PURPOSE
//  Sequencer feeding the 16-bit hex word input of the four-digit seven-segment display driver.
//  Accepts a message of up to MSG_NIBBLES hex digits over a valid/ready load handshake.
//  Scrolls a 4-digit window across the message, one nibble per TICK_DIV clocks.
//  Supports pause, abort and a one-cycle done pulse per completed pass.
// PARAMETERS
//  MSG_NIBBLES  16          max message length in hex digits (>=4)
//  TICK_DIV     25_000_000  clock cycles per scroll step (>=2)
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst        in   1                  reset, asynchronous, active-high
//  msg_valid  in   1                  load request
//  msg_ready  out  1                  high while IDLE; load occurs on valid&ready
//  msg_data   in   4*MSG_NIBBLES      nibble k = msg_data[4k+3:4k]
//  msg_len    in   $clog2(MSG_NIBBLES)+1  message length in nibbles
//  pause      in   1                  freezes tick counter and window while high
//  abort      in   1                  ends a running scroll
//  disp_word  out  16                 to display driver; [15:12] = leftmost digit
//  busy       out  1                  high in RUN
//  done       out  1                  one-cycle pulse at end of a pass
// BEHAVIOUR
//  - Reset: state=IDLE, pos=0, tick=0, buffer=0, len=4, disp_word=16'h0000, done=0.
//    Resulting outputs: msg_ready=1, busy=0. Reset acts immediately, including mid-scroll.
//  - States are IDLE and RUN.
//  - IDLE -> RUN on msg_valid&msg_ready:
//    - Latch msg_data.
//    - len = clamp(msg_len, 4, MSG_NIBBLES).
//    - pos=0, tick=0.
//  - Window: disp_word = {nib[pos], nib[(pos+1)%len], nib[(pos+2)%len], nib[(pos+3)%len]}.
//  - disp_word is registered.
//    - The window for the new pos appears on the edge after a load or step (1-cycle latency).
//  - RUN, pause=0: tick increments each cycle.
//    - At tick==TICK_DIV-1: tick->0 and pos->pos+1 (a step).
//  - RUN, pause=1: tick, pos and disp_word hold. Counting resumes from the held tick value.
//  - End of pass is a step with pos==len-1:
//    - pos->0, disp_word shows window 0, done=1 for one cycle.
//    - State -> IDLE, except when SEG_SCROLL_LOOP_EN is defined (see CONFIGURATION).
//  - abort in RUN -> IDLE on the next edge; disp_word holds, done stays 0.
//    - abort beats a simultaneous step or end of pass, and beats pause.
//    - abort in IDLE is ignored.
//  - msg_valid in RUN: not accepted (msg_ready=0). The requester keeps msg_valid asserted.
//  - msg_data/msg_len changes after the load have no effect.
// CONFIGURATION
//  - SEG_SCROLL_LOOP_EN defined:
//    - End of pass wraps pos to 0 and stays in RUN.
//    - done pulses once per pass; leaving RUN is only by abort or rst.
//  - Undefined: one-shot; end of pass returns to IDLE with window 0 shown.
// STRUCTURE
//  - Package seg_scroll_pkg:
//    - State typedef {IDLE, RUN}.
//    - Constants DISP_DIGITS=4, NIB_W=4.
//    - Clamp function for len.
//  - Sub-module seg_scroll_window: combinational selection of 4 nibbles from the buffer by pos and len, modulo len.
//  - Top holds the FSM, tick counter, pos counter, buffer and output registers.
// TESTING (TICK_DIV=4, MSG_NIBBLES=8)
//  1. Reset asserted -> disp_word=16'h0000, msg_ready=1, busy=0, done=0.
//  2. Load 32'h76543210, len=8 -> next cycle disp_word=16'h0123.
//     Then every 4 cycles: 16'h1234 ... 16'h7012.
//     After 8th step: done pulse, disp_word=16'h0123, IDLE (one-shot).
//  3. pause high 10 cycles at pos 2 -> disp_word holds 16'h2345.
//     After release, next step occurs after remaining tick count.
//  4. abort at pos 5 (16'h5670) -> IDLE next edge, disp_word=16'h5670, done=0.
//     Simultaneous abort with step -> no step.
//  5. len=2 -> scroll behaves as len=4 (4 steps per pass). len=12 -> behaves as len=8.
//  6. rst pulsed mid-RUN, between clock edges -> disp_word=0, busy=0 immediately.
//     With SEG_SCROLL_LOOP_EN: 3 consecutive passes give 3 done pulses, busy stays 1.

Source files
------------

// File: rtl/seg_scroll_pkg.sv
// Shared types, constants and the message-length clamp for the seven-segment scroll sequencer.
package seg_scroll_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DISP_DIGITS = 32'd4;
  localparam int unsigned NIB_W       = 32'd4;

  // Messages shorter than the window are padded out to a full window; longer ones are cut to the buffer size.
  function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_len);
    int unsigned res;
    if (req < DISP_DIGITS) begin
      res = DISP_DIGITS;
    end else if (req > max_len) begin
      res = max_len;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scroll_window.sv
// Combinational 4-digit window over the message buffer, indices taken modulo len.
module seg_scroll_window
  import seg_scroll_pkg::*;
#(
  parameter int MSG_NIBBLES = 16,
  parameter int POS_W       = $clog2(MSG_NIBBLES),
  parameter int LEN_W       = POS_W + 1
) (
  input  logic [NIB_W*MSG_NIBBLES-1:0] nibbles,
  input  logic [POS_W-1:0]             pos,
  input  logic [LEN_W-1:0]             len,
  output logic [NIB_W*DISP_DIGITS-1:0] word
);

  // pos < len and len >= 4, so pos+g < 2*len and one conditional subtract replaces a modulo.
  for (genvar g = 0; g < DISP_DIGITS; g++) begin : g_digit
    logic [LEN_W-1:0] raw_s;
    logic [LEN_W-1:0] idx_s;
    assign raw_s = LEN_W'(pos) + LEN_W'(g);
    assign idx_s = (raw_s >= len) ? (raw_s - len) : raw_s;
    assign word[NIB_W*(DISP_DIGITS-1-g) +: NIB_W] = nibbles[NIB_W*idx_s +: NIB_W];
  end

endmodule

// File: rtl/seven_seg_scroll_ctrl.sv
// Scroll sequencer feeding a 4-digit hex display driver from a loaded message buffer.
// Define SEG_SCROLL_LOOP_EN to repeat passes until abort instead of stopping after one.
module seven_seg_scroll_ctrl
  import seg_scroll_pkg::*;
#(
  parameter int MSG_NIBBLES = 16,
  parameter int TICK_DIV    = 25_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              msg_valid,
  output logic                              msg_ready,
  input  logic [4*MSG_NIBBLES-1:0]          msg_data,
  input  logic [$clog2(MSG_NIBBLES):0]      msg_len,
  input  logic                              pause,
  input  logic                              abort,
  output logic [15:0]                       disp_word,
  output logic                              busy,
  output logic                              done
);

  localparam int POS_W  = $clog2(MSG_NIBBLES);
  localparam int LEN_W  = POS_W + 1;
  localparam int TICK_W = $clog2(TICK_DIV);

  state_t                      state_r;
  logic [POS_W-1:0]            pos_r;
  logic [TICK_W-1:0]           tick_r;
  logic [NIB_W*MSG_NIBBLES-1:0] msg_buf_r;
  logic [LEN_W-1:0]            len_r;
  logic [15:0]                 disp_word_r;
  logic                        done_r;

  logic [15:0]                 window_s;
  logic [LEN_W-1:0]            len_load_s;
  logic                        tick_wrap_s;
  logic                        last_pos_s;

  assign len_load_s  = LEN_W'(clamp_len(32'(msg_len), unsigned'(MSG_NIBBLES)));
  assign tick_wrap_s = (tick_r == TICK_W'(TICK_DIV - 1));
  assign last_pos_s  = (LEN_W'(pos_r) == (len_r - LEN_W'(1)));

  seg_scroll_window #(
    .MSG_NIBBLES (MSG_NIBBLES),
    .POS_W       (POS_W),
    .LEN_W       (LEN_W)
  ) u_window (
    .nibbles (msg_buf_r),
    .pos     (pos_r),
    .len     (len_r),
    .word    (window_s)
  );

  // Display follows the window of the registered pos, so it trails every load or step by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pos_r       <= '0;
      tick_r      <= '0;
      msg_buf_r   <= '0;
      len_r       <= LEN_W'(DISP_DIGITS);
      disp_word_r <= 16'h0000;
      done_r      <= 1'b0;
    end else begin
      disp_word_r <= window_s;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (msg_valid) begin
            msg_buf_r <= msg_data;
            len_r     <= len_load_s;
            pos_r     <= '0;
            tick_r    <= '0;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_r <= IDLE;
          end else if (!pause) begin
            if (tick_wrap_s) begin
              tick_r <= '0;
              if (last_pos_s) begin
                pos_r  <= '0;
                done_r <= 1'b1;
`ifndef SEG_SCROLL_LOOP_EN
                state_r <= IDLE;
`endif
              end else begin
                pos_r <= pos_r + POS_W'(1);
              end
            end else begin
              tick_r <= tick_r + TICK_W'(1);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign msg_ready = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign disp_word = disp_word_r;
  assign done      = done_r;

endmodule

// File: tb/tb_seven_seg_scroll_ctrl.sv
// Directed bench for seven_seg_scroll_ctrl with MSG_NIBBLES=8, TICK_DIV=4.
module tb_seven_seg_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_data;
  logic [3:0]  msg_len;
  logic        pause;
  logic        abort;
  logic [15:0] disp_word;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp8 [8] = '{16'h0123, 16'h1234, 16'h2345, 16'h3456,
                            16'h4567, 16'h5670, 16'h6701, 16'h7012};

  seven_seg_scroll_ctrl #(.MSG_NIBBLES(8), .TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .msg_len   (msg_len),
    .pause     (pause),
    .abort     (abort),
    .disp_word (disp_word),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] data, input logic [3:0] len);
    msg_valid = 1'b1;
    msg_data  = data;
    msg_len   = len;
    cyc(1);
    msg_valid = 1'b0;
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_ready", {31'd0, msg_ready}, 32'd0);
  endtask

  // Called on the edge that ends a pass; leaves the DUT idle in both builds.
  task automatic end_of_pass(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
`ifdef SEG_SCROLL_LOOP_EN
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
`else
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    cyc(1);
`endif
    chk({tag, "_win0"}, {16'd0, disp_word}, 32'h0000_0123);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; msg_valid = 1'b0; msg_data = 32'd0; msg_len = 4'd0;
    pause = 1'b0; abort = 1'b0;
    cyc(2);
    chk("rst_disp", {16'd0, disp_word}, 32'h0000_0000);
    chk("rst_ready", {31'd0, msg_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    cyc(1);

    // Full 8-nibble one-shot pass
    load(32'h7654_3210, 4'd8);
    cyc(1);
    chk("scroll_0", {16'd0, disp_word}, {16'd0, exp8[0]});
    for (int k = 1; k < 8; k++) begin
      cyc(4);
      chk($sformatf("scroll_%0d", k), {16'd0, disp_word}, {16'd0, exp8[k]});
    end
    cyc(3);
    end_of_pass("pass8");

    // Pause at pos 2, then abort coinciding with the step out of pos 5
    load(32'h7654_3210, 4'd8);
    cyc(1);
    chk("p_win0", {16'd0, disp_word}, 32'h0000_0123);
    cyc(8);
    chk("p_win2", {16'd0, disp_word}, 32'h0000_2345);
    pause = 1'b1;
    cyc(10);
    chk("p_hold", {16'd0, disp_word}, 32'h0000_2345);
    chk("p_busy", {31'd0, busy}, 32'd1);
    pause = 1'b0;
    cyc(3);
    chk("p_resume_wait", {16'd0, disp_word}, 32'h0000_2345);
    cyc(1);
    chk("p_resume_step", {16'd0, disp_word}, 32'h0000_3456);
    cyc(8);
    chk("a_win5", {16'd0, disp_word}, 32'h0000_5670);
    cyc(2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("a_busy", {31'd0, busy}, 32'd0);
    chk("a_ready", {31'd0, msg_ready}, 32'd1);
    chk("a_done", {31'd0, done}, 32'd0);
    cyc(1);
    chk("a_nostep", {16'd0, disp_word}, 32'h0000_5670);
    chk("a_done2", {31'd0, done}, 32'd0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("a_idle_ready", {31'd0, msg_ready}, 32'd1);
    chk("a_idle_disp", {16'd0, disp_word}, 32'h0000_5670);

    // len=2 clamps to 4; a request during RUN must be ignored
    load(32'hFEDC_3210, 4'd2);
    cyc(1);
    chk("l2_win0", {16'd0, disp_word}, 32'h0000_0123);
    msg_valid = 1'b1;
    msg_data  = 32'hAAAA_AAAA;
    msg_len   = 4'd8;
    cyc(4);
    chk("l2_win1", {16'd0, disp_word}, 32'h0000_1230);
    chk("l2_ready_run", {31'd0, msg_ready}, 32'd0);
    msg_valid = 1'b0;
    cyc(4);
    chk("l2_win2", {16'd0, disp_word}, 32'h0000_2301);
    cyc(4);
    chk("l2_win3", {16'd0, disp_word}, 32'h0000_3012);
    cyc(3);
    end_of_pass("pass_l2");

    // len=12 clamps to 8
    load(32'h7654_3210, 4'd12);
    cyc(1);
    chk("l12_win0", {16'd0, disp_word}, 32'h0000_0123);
    cyc(28);
    chk("l12_win7", {16'd0, disp_word}, 32'h0000_7012);
    cyc(3);
    end_of_pass("pass_l12");

    // Asynchronous reset between edges
    load(32'h7654_3210, 4'd8);
    cyc(5);
    chk("r_win1", {16'd0, disp_word}, 32'h0000_1234);
    #2 rst = 1'b1;
    #1;
    chk("r_disp", {16'd0, disp_word}, 32'h0000_0000);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_ready", {31'd0, msg_ready}, 32'd1);
    #1 rst = 1'b0;
    cyc(1);

`ifdef SEG_SCROLL_LOOP_EN
    begin
      int pulses = 0;
      load(32'h0000_3210, 4'd4);
      for (int c = 0; c < 50; c++) begin
        cyc(1);
        if (done) pulses++;
        chk("loop_busy", {31'd0, busy}, 32'd1);
      end
      chk("loop_pulses", pulses, 32'd3);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("loop_abort", {31'd0, busy}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
